// File: rtl/bus_control_sequencer.sv
// bus_control_sequencer: clocked PIC bus-control front end.
// Synchronises the CPU strobes, A0 and data, detects one write event per access,
// runs the ICW1->ICW2->[ICW3]->[ICW4] init sequence and emits one-cycle decoded
// ICW/OCW pulses together with the captured data word.
// Optional feature macro: BUS_CONTROL_SEQ_ERROR_EN adds a sticky seq_error output
// that flags writes dropped because they do not fit the current sequence state.
module bus_control_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  chip_select_n,
    input  logic                  read_enable_n,
    input  logic                  write_enable_n,
    input  logic                  A0,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    output logic [DATA_WIDTH-1:0] internal_data_bus,
    output logic                  write_icw1,
    output logic                  write_icw2,
    output logic                  write_icw3,
    output logic                  write_icw4,
    output logic                  write_ocw1,
    output logic                  write_ocw2,
    output logic                  write_ocw3,
    output logic                  read,
    output logic                  init_done,
    output logic                  single_mode,
    output logic                  icw4_needed
`ifdef BUS_CONTROL_SEQ_ERROR_EN
    ,
    output logic                  seq_error
`endif
);

    localparam int SW = DATA_WIDTH + 3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_t;

    state_t                  state;
    logic [SW-1:0]           raw_bus;
    logic [SW-1:0]           sync_bus;
    logic                    wr_q;
    logic                    rd_q;
    logic                    a0_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    wr_prev;
    logic                    wr_event;

    // Strobes are qualified by chip select before synchronising so that the
    // strobe, A0 and data all travel through the same stage count together.
    assign raw_bus = {~chip_select_n & ~write_enable_n,
                      ~chip_select_n & ~read_enable_n,
                      A0, data_bus_in};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_bus = raw_bus;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][SW-1:0] stage;

            // Input synchroniser shift register for strobes, A0 and data.
            always_ff @(posedge clock) begin
                if (reset) begin
                    stage <= '0;
                end else begin
                    stage[0] <= raw_bus;
                    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign sync_bus = stage[SYNC_STAGES-1];
        end
    endgenerate

    assign {wr_q, rd_q, a0_q, data_q} = sync_bus;
    assign wr_event = wr_q & ~wr_prev;

    // Init-sequence FSM with registered decode pulses, read level and status.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            wr_prev           <= 1'b0;
            read              <= 1'b0;
            init_done         <= 1'b0;
            single_mode       <= 1'b0;
            icw4_needed       <= 1'b0;
            internal_data_bus <= '0;
            write_icw1        <= 1'b0;
            write_icw2        <= 1'b0;
            write_icw3        <= 1'b0;
            write_icw4        <= 1'b0;
            write_ocw1        <= 1'b0;
            write_ocw2        <= 1'b0;
            write_ocw3        <= 1'b0;
`ifdef BUS_CONTROL_SEQ_ERROR_EN
            seq_error         <= 1'b0;
`endif
        end else begin
            wr_prev    <= wr_q;
            read       <= rd_q & ~wr_q;
            init_done  <= (state == READY);
            write_icw1 <= 1'b0;
            write_icw2 <= 1'b0;
            write_icw3 <= 1'b0;
            write_icw4 <= 1'b0;
            write_ocw1 <= 1'b0;
            write_ocw2 <= 1'b0;
            write_ocw3 <= 1'b0;
            if (wr_event) begin
                if (!a0_q && data_q[4]) begin
                    write_icw1        <= 1'b1;
                    single_mode       <= data_q[1];
                    icw4_needed       <= data_q[0];
                    internal_data_bus <= data_q;
                    state             <= WAIT_ICW2;
`ifdef BUS_CONTROL_SEQ_ERROR_EN
                    seq_error         <= 1'b0;
`endif
                end else if (a0_q) begin
                    case (state)
                        WAIT_ICW2: begin
                            write_icw2        <= 1'b1;
                            internal_data_bus <= data_q;
                            state <= !single_mode ? WAIT_ICW3 :
                                     icw4_needed  ? WAIT_ICW4 : READY;
                        end
                        WAIT_ICW3: begin
                            write_icw3        <= 1'b1;
                            internal_data_bus <= data_q;
                            state <= icw4_needed ? WAIT_ICW4 : READY;
                        end
                        WAIT_ICW4: begin
                            write_icw4        <= 1'b1;
                            internal_data_bus <= data_q;
                            state             <= READY;
                        end
                        READY: begin
                            write_ocw1        <= 1'b1;
                            internal_data_bus <= data_q;
                        end
                        default: begin
`ifdef BUS_CONTROL_SEQ_ERROR_EN
                            seq_error <= 1'b1;
`endif
                        end
                    endcase
                end else if (state == READY) begin
                    write_ocw2        <= ~data_q[3];
                    write_ocw3        <= data_q[3];
                    internal_data_bus <= data_q;
                end else begin
`ifdef BUS_CONTROL_SEQ_ERROR_EN
                    seq_error <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_control_sequencer.sv
// tb_bus_control_sequencer: randomized and directed checks of bus_control_sequencer
// against a queue-based model of the init sequence (pending ICWs held in a queue).
// Pulse timing convention: the first posedge that samples the strobe low is edge 1;
// the decoded pulse is high right after edge SYNC_STAGES+1, and init_done follows
// the FSM one edge later.
module tb_bus_control_sequencer;

    localparam int S = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       chip_select_n = 1'b1;
    logic       read_enable_n = 1'b1;
    logic       write_enable_n = 1'b1;
    logic       A0 = 1'b0;
    logic [7:0] data_bus_in = '0;
    logic [7:0] internal_data_bus;
    logic       write_icw1, write_icw2, write_icw3, write_icw4;
    logic       write_ocw1, write_ocw2, write_ocw3;
    logic       read, init_done, single_mode, icw4_needed;
`ifdef BUS_CONTROL_SEQ_ERROR_EN
    logic       seq_error;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: queue of ICW numbers still owed, plus latched status.
    int         m_queue[$];
    bit         m_ready = 1'b0;
    logic       m_sngl  = 1'b0;
    logic       m_ic4   = 1'b0;
    logic [7:0] m_data  = '0;
    bit         m_err   = 1'b0;

    bus_control_sequencer #(
        .DATA_WIDTH (8),
        .SYNC_STAGES(S)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .chip_select_n    (chip_select_n),
        .read_enable_n    (read_enable_n),
        .write_enable_n   (write_enable_n),
        .A0               (A0),
        .data_bus_in      (data_bus_in),
        .internal_data_bus(internal_data_bus),
        .write_icw1       (write_icw1),
        .write_icw2       (write_icw2),
        .write_icw3       (write_icw3),
        .write_icw4       (write_icw4),
        .write_ocw1       (write_ocw1),
        .write_ocw2       (write_ocw2),
        .write_ocw3       (write_ocw3),
        .read             (read),
        .init_done        (init_done),
        .single_mode      (single_mode),
        .icw4_needed      (icw4_needed)
`ifdef BUS_CONTROL_SEQ_ERROR_EN
        ,
        .seq_error        (seq_error)
`endif
    );

    always #5 clock = ~clock;

    // Code: 0 none, 1..4 ICW1..ICW4, 5..7 OCW1..OCW3.
    task automatic model_write(input bit a0, input logic [7:0] d, output int code);
        code = 0;
        if (!a0 && d[4]) begin
            code   = 1;
            m_sngl = d[1];
            m_ic4  = d[0];
            m_queue.delete();
            m_queue.push_back(2);
            if (!d[1]) m_queue.push_back(3);
            if (d[0])  m_queue.push_back(4);
            m_ready = 1'b0;
            m_data  = d;
            m_err   = 1'b0;
        end else if (a0) begin
            if (m_queue.size() > 0) begin
                code = m_queue.pop_front();
                m_data = d;
                if (m_queue.size() == 0) m_ready = 1'b1;
            end else if (m_ready) begin
                code = 5;
                m_data = d;
            end else begin
                m_err = 1'b1;
            end
        end else if (m_ready) begin
            code = d[3] ? 7 : 6;
            m_data = d;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_queue.delete();
        m_ready = 1'b0;
        m_sngl  = 1'b0;
        m_ic4   = 1'b0;
        m_data  = '0;
        m_err   = 1'b0;
    endtask

    // One CPU write held for 'hold' edges, checked every cycle of its window.
    task automatic access(input bit a0, input logic [7:0] d, input int hold, input bit with_rd);
        int         code;
        logic [6:0] exp_vec, obs_vec;
        logic [7:0] old_data;
        logic       old_sngl, old_ic4;
        bit         old_ready, old_err;
        old_data  = m_data;
        old_sngl  = m_sngl;
        old_ic4   = m_ic4;
        old_ready = m_ready;
        old_err   = m_err;
        model_write(a0, d, code);
        exp_vec = (code == 0) ? 7'b0 : (7'b1000000 >> (code - 1));
        @(negedge clock);
        chip_select_n  = 1'b0;
        write_enable_n = 1'b0;
        read_enable_n  = ~with_rd;
        A0             = a0;
        data_bus_in    = d;
        for (int k = 1; k <= hold + S + 3; k++) begin
            @(posedge clock);
            #1;
            obs_vec = {write_icw1, write_icw2, write_icw3, write_icw4,
                       write_ocw1, write_ocw2, write_ocw3};
            n_total++;
            if (obs_vec !== ((k == S + 1) ? exp_vec : 7'b0))
                $display("FAIL pulses a0=%0b d=%h edge %0d: got %b want %b",
                         a0, d, k, obs_vec, (k == S + 1) ? exp_vec : 7'b0);
            else n_pass++;
            n_total++;
            if (read !== 1'b0) $display("FAIL read_during_write edge %0d: got %b want 0", k, read);
            else n_pass++;
            n_total++;
            if (internal_data_bus !== ((k <= S) ? old_data : m_data))
                $display("FAIL data edge %0d: got %h want %h", k, internal_data_bus,
                         (k <= S) ? old_data : m_data);
            else n_pass++;
            n_total++;
            if ({single_mode, icw4_needed} !== ((k <= S) ? {old_sngl, old_ic4} : {m_sngl, m_ic4}))
                $display("FAIL sngl_ic4 edge %0d: got %b%b want %b", k, single_mode, icw4_needed,
                         (k <= S) ? {old_sngl, old_ic4} : {m_sngl, m_ic4});
            else n_pass++;
            n_total++;
            if (init_done !== ((k <= S + 1) ? old_ready : m_ready))
                $display("FAIL init_done edge %0d: got %b want %b", k, init_done,
                         (k <= S + 1) ? old_ready : m_ready);
            else n_pass++;
`ifdef BUS_CONTROL_SEQ_ERROR_EN
            n_total++;
            if (seq_error !== ((k <= S) ? old_err : m_err))
                $display("FAIL seq_error edge %0d: got %b want %b", k, seq_error,
                         (k <= S) ? old_err : m_err);
            else n_pass++;
`endif
            if (k == hold) begin
                chip_select_n  = 1'b1;
                write_enable_n = 1'b1;
                read_enable_n  = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        n_total++;
        if ({internal_data_bus, write_icw1, write_icw2, write_icw3, write_icw4, write_ocw1,
             write_ocw2, write_ocw3, read, init_done, single_mode, icw4_needed} !== '0)
            $display("FAIL reset_outputs: got nonzero data=%h init_done=%b", internal_data_bus, init_done);
        else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        // Abort mid-sequence while waiting for ICW2.
        access(1'b0, 8'h13, 1, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_total++;
        if ({internal_data_bus, write_icw1, write_icw2, write_icw3, write_icw4, write_ocw1,
             write_ocw2, write_ocw3, read, init_done, single_mode, icw4_needed} !== '0)
            $display("FAIL reset_midseq: got data=%h sngl=%b ic4=%b", internal_data_bus,
                     single_mode, icw4_needed);
        else n_pass++;
`ifdef BUS_CONTROL_SEQ_ERROR_EN
        n_total++;
        if (seq_error !== 1'b0) $display("FAIL reset_seq_error: got %b want 0", seq_error);
        else n_pass++;
`endif
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        // A0=1 must now be dropped because the FSM is back in IDLE.
        access(1'b1, 8'h55, 1, 1'b0);
    endtask

    task automatic test_icw_no_icw4();
        access(1'b0, 8'h10, 1, 1'b0);
        access(1'b1, 8'h00, 2, 1'b0);
        access(1'b1, 8'h04, 1, 1'b0);
        n_total++;
        if ({init_done, internal_data_bus} !== {1'b1, 8'h04})
            $display("FAIL icw_seq3_end: got init_done=%b data=%h want 1 04", init_done, internal_data_bus);
        else n_pass++;
    endtask

    task automatic test_icw_single_icw4();
        access(1'b0, 8'h13, 1, 1'b0);
        access(1'b1, 8'h20, 1, 1'b0);
        access(1'b1, 8'h01, 1, 1'b0);
        n_total++;
        if ({init_done, single_mode, icw4_needed} !== 3'b111)
            $display("FAIL icw_seq4_end: got %b%b%b want 111", init_done, single_mode, icw4_needed);
        else n_pass++;
    endtask

    task automatic test_ocw();
        access(1'b1, 8'hFF, 5, 1'b0);
        access(1'b0, 8'h20, 1, 1'b0);
        access(1'b0, 8'h08, 3, 1'b0);
        // Restart from READY: init_done lags the FSM and falls after the ICW1 pulse.
        access(1'b0, 8'h12, 1, 1'b0);
        access(1'b1, 8'hA5, 1, 1'b0);
        n_total++;
        if (init_done !== 1'b1) $display("FAIL restart_ready: got %b want 1", init_done);
        else n_pass++;
    endtask

    task automatic test_read_write();
        access(1'b1, 8'h3C, 2, 1'b1);
        @(negedge clock);
        chip_select_n = 1'b0;
        read_enable_n = 1'b0;
        repeat (S + 2) @(posedge clock);
        #1;
        n_total++;
        if ({read, write_icw1, write_ocw1, write_ocw2, write_ocw3} !== 5'b10000)
            $display("FAIL read_only: got read=%b ocw1=%b want 1 0", read, write_ocw1);
        else n_pass++;
        chip_select_n = 1'b1;
        read_enable_n = 1'b1;
        repeat (S + 2) @(posedge clock);
        #1;
        n_total++;
        if (read !== 1'b0) $display("FAIL read_release: got %b want 0", read);
        else n_pass++;
    endtask

    task automatic test_drop_idle();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        access(1'b0, 8'h20, 1, 1'b0);
        access(1'b0, 8'h08, 1, 1'b0);
        access(1'b0, 8'h11, 1, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] d;
        bit         a0;
        for (int n = 0; n < 60; n++) begin
            a0 = $urandom_range(0, 1) == 1;
            d  = 8'($urandom);
            if (!a0 && $urandom_range(0, 2) != 0) d[4] = 1'b0;
            access(a0, d, $urandom_range(1, 4), $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_icw_no_icw4();
        test_icw_single_icw4();
        test_ocw();
        test_read_write();
        test_drop_idle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
